// File: rtl/axi4_burst_initiator.sv
// AXI4 master that turns one command into one INCR read or write burst.
// Only one transaction is in flight; R/W beats stream through combinationally.
module axi4_burst_initiator #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned STRB_BITS = DATA_BITS / 8
) (
    input  logic                 clock,
    input  logic                 reset_n,

    input  logic                 io_cmd_valid,
    output logic                 io_cmd_ready,
    input  logic                 io_cmd_bits_write,
    input  logic [ADDR_BITS-1:0] io_cmd_bits_addr,
    input  logic [7:0]           io_cmd_bits_len,
    input  logic [ID_BITS-1:0]   io_cmd_bits_id,

    input  logic                 io_wdata_valid,
    output logic                 io_wdata_ready,
    input  logic [DATA_BITS-1:0] io_wdata_bits_data,
    input  logic [STRB_BITS-1:0] io_wdata_bits_strb,

    output logic                 io_rdata_valid,
    input  logic                 io_rdata_ready,
    output logic [DATA_BITS-1:0] io_rdata_bits_data,
    output logic [1:0]           io_rdata_bits_resp,
    output logic                 io_rdata_bits_last,

    output logic                 io_wresp_valid,
    input  logic                 io_wresp_ready,
    output logic [1:0]           io_wresp_bits_resp,

    output logic                 io_busy,
    output logic                 io_err_proto,

    output logic                 io_mem_ar_valid,
    input  logic                 io_mem_ar_ready,
    output logic [ID_BITS-1:0]   io_mem_ar_bits_id,
    output logic [ADDR_BITS-1:0] io_mem_ar_bits_addr,
    output logic [7:0]           io_mem_ar_bits_len,
    output logic [2:0]           io_mem_ar_bits_size,
    output logic [1:0]           io_mem_ar_bits_burst,
    output logic                 io_mem_ar_bits_lock,
    output logic [3:0]           io_mem_ar_bits_cache,
    output logic [2:0]           io_mem_ar_bits_prot,
    output logic [3:0]           io_mem_ar_bits_qos,
    output logic [3:0]           io_mem_ar_bits_region,
    output logic                 io_mem_ar_bits_user,

    output logic                 io_mem_aw_valid,
    input  logic                 io_mem_aw_ready,
    output logic [ID_BITS-1:0]   io_mem_aw_bits_id,
    output logic [ADDR_BITS-1:0] io_mem_aw_bits_addr,
    output logic [7:0]           io_mem_aw_bits_len,
    output logic [2:0]           io_mem_aw_bits_size,
    output logic [1:0]           io_mem_aw_bits_burst,
    output logic                 io_mem_aw_bits_lock,
    output logic [3:0]           io_mem_aw_bits_cache,
    output logic [2:0]           io_mem_aw_bits_prot,
    output logic [3:0]           io_mem_aw_bits_qos,
    output logic [3:0]           io_mem_aw_bits_region,
    output logic                 io_mem_aw_bits_user,

    output logic                 io_mem_w_valid,
    input  logic                 io_mem_w_ready,
    output logic [DATA_BITS-1:0] io_mem_w_bits_data,
    output logic [STRB_BITS-1:0] io_mem_w_bits_strb,
    output logic                 io_mem_w_bits_last,
    output logic                 io_mem_w_bits_user,

    input  logic                 io_mem_r_valid,
    output logic                 io_mem_r_ready,
    input  logic [ID_BITS-1:0]   io_mem_r_bits_id,
    input  logic [DATA_BITS-1:0] io_mem_r_bits_data,
    input  logic [1:0]           io_mem_r_bits_resp,
    input  logic                 io_mem_r_bits_last,

    input  logic                 io_mem_b_valid,
    output logic                 io_mem_b_ready,
    input  logic [ID_BITS-1:0]   io_mem_b_bits_id,
    input  logic [1:0]           io_mem_b_bits_resp
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdAddr = 3'd1;
    localparam logic [2:0] StRdData = 3'd2;
    localparam logic [2:0] StWrAddr = 3'd3;
    localparam logic [2:0] StWrData = 3'd4;
    localparam logic [2:0] StWrResp = 3'd5;
    localparam logic [2:0] StWrDone = 3'd6;

    localparam int unsigned SizeLog = $clog2(STRB_BITS);
    localparam logic [2:0]  AxSize  = 3'(SizeLog);

    logic [2:0]           state_q, state_d;
    logic [7:0]           beat_q, beat_d;
    logic [ADDR_BITS-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]           ar_len_q, ar_len_d;
    logic [ID_BITS-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_BITS-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]           aw_len_q, aw_len_d;
    logic [ID_BITS-1:0]   aw_id_q, aw_id_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 err_q, err_d;

    logic r_fire;
    logic w_fire;
    logic rd_at_len;
    logic wr_at_len;

    assign rd_at_len = (beat_q == ar_len_q);
    assign wr_at_len = (beat_q == aw_len_q);
    assign r_fire    = (state_q == StRdData) && io_mem_r_valid && io_rdata_ready;
    assign w_fire    = (state_q == StWrData) && io_wdata_valid && io_mem_w_ready;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_id_d   = ar_id_q;
        aw_addr_d = aw_addr_q;
        aw_len_d  = aw_len_q;
        aw_id_d   = aw_id_q;
        bresp_d   = bresp_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (io_cmd_valid) begin
                    if (io_cmd_bits_write) begin
                        aw_addr_d = io_cmd_bits_addr;
                        aw_len_d  = io_cmd_bits_len;
                        aw_id_d   = io_cmd_bits_id;
                        state_d   = StWrAddr;
                    end else begin
                        ar_addr_d = io_cmd_bits_addr;
                        ar_len_d  = io_cmd_bits_len;
                        ar_id_d   = io_cmd_bits_id;
                        state_d   = StRdAddr;
                    end
                end
            end
            StRdAddr: begin
                if (io_mem_ar_ready) begin
                    beat_d  = 8'd0;
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (r_fire) begin
                    beat_d = beat_q + 8'd1;
                    // Early last or missing last are both protocol violations;
                    // only a beat carrying r_last ends the burst.
                    if (io_mem_r_bits_last != rd_at_len) begin
                        err_d = 1'b1;
                    end
                    if (io_mem_r_bits_id != ar_id_q) begin
                        err_d = 1'b1;
                    end
                    if (io_mem_r_bits_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrAddr: begin
                if (io_mem_aw_ready) begin
                    beat_d  = 8'd0;
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (w_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (wr_at_len) begin
                        state_d = StWrResp;
                    end
                end
            end
            StWrResp: begin
                if (io_mem_b_valid) begin
                    bresp_d = io_mem_b_bits_resp;
                    if (io_mem_b_bits_id != aw_id_q) begin
                        err_d = 1'b1;
                    end
                    state_d = StWrDone;
                end
            end
            StWrDone: begin
                if (io_wresp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            beat_q    <= 8'd0;
            ar_addr_q <= '0;
            ar_len_q  <= 8'd0;
            ar_id_q   <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= 8'd0;
            aw_id_q   <= '0;
            bresp_q   <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_id_q   <= ar_id_d;
            aw_addr_q <= aw_addr_d;
            aw_len_q  <= aw_len_d;
            aw_id_q   <= aw_id_d;
            bresp_q   <= bresp_d;
            err_q     <= err_d;
        end
    end

    assign io_cmd_ready = (state_q == StIdle);
    assign io_busy      = (state_q != StIdle);
    assign io_err_proto = err_q;

    assign io_mem_ar_valid       = (state_q == StRdAddr);
    assign io_mem_ar_bits_id     = ar_id_q;
    assign io_mem_ar_bits_addr   = ar_addr_q;
    assign io_mem_ar_bits_len    = ar_len_q;
    assign io_mem_ar_bits_size   = AxSize;
    assign io_mem_ar_bits_burst  = 2'b01;
    assign io_mem_ar_bits_lock   = 1'b0;
    assign io_mem_ar_bits_cache  = 4'd0;
    assign io_mem_ar_bits_prot   = 3'd0;
    assign io_mem_ar_bits_qos    = 4'd0;
    assign io_mem_ar_bits_region = 4'd0;
    assign io_mem_ar_bits_user   = 1'b0;

    assign io_mem_aw_valid       = (state_q == StWrAddr);
    assign io_mem_aw_bits_id     = aw_id_q;
    assign io_mem_aw_bits_addr   = aw_addr_q;
    assign io_mem_aw_bits_len    = aw_len_q;
    assign io_mem_aw_bits_size   = AxSize;
    assign io_mem_aw_bits_burst  = 2'b01;
    assign io_mem_aw_bits_lock   = 1'b0;
    assign io_mem_aw_bits_cache  = 4'd0;
    assign io_mem_aw_bits_prot   = 3'd0;
    assign io_mem_aw_bits_qos    = 4'd0;
    assign io_mem_aw_bits_region = 4'd0;
    assign io_mem_aw_bits_user   = 1'b0;

    assign io_mem_w_valid     = (state_q == StWrData) && io_wdata_valid;
    assign io_wdata_ready     = (state_q == StWrData) && io_mem_w_ready;
    assign io_mem_w_bits_data = io_wdata_bits_data;
    assign io_mem_w_bits_strb = io_wdata_bits_strb;
    assign io_mem_w_bits_last = wr_at_len;
    assign io_mem_w_bits_user = 1'b0;

    assign io_mem_r_ready     = (state_q == StRdData) && io_rdata_ready;
    assign io_rdata_valid     = (state_q == StRdData) && io_mem_r_valid;
    assign io_rdata_bits_data = io_mem_r_bits_data;
    assign io_rdata_bits_resp = io_mem_r_bits_resp;
    assign io_rdata_bits_last = io_mem_r_bits_last;

    assign io_mem_b_ready     = (state_q == StWrResp);
    assign io_wresp_valid     = (state_q == StWrDone);
    assign io_wresp_bits_resp = bresp_q;

endmodule

// File: tb/tb_axi4_burst_initiator.sv
// Bench for axi4_burst_initiator: a table of burst commands against a simple AXI
// slave model, a beat scoreboard, and a hand-written reset-mid-burst sequence.
module tb_axi4_burst_initiator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        wdata_valid, wdata_ready;
    logic [63:0] wdata_data;
    logic [7:0]  wdata_strb;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic [63:0] rdata_data;
    logic [1:0]  rdata_resp;
    logic        wresp_valid, wresp_ready;
    logic [1:0]  wresp_resp;
    logic        busy, err_proto;
    logic        ar_valid, ar_ready, ar_lock, ar_user;
    logic [3:0]  ar_id, ar_cache, ar_qos, ar_region;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size, ar_prot;
    logic [1:0]  ar_burst;
    logic        aw_valid, aw_ready, aw_lock, aw_user;
    logic [3:0]  aw_id, aw_cache, aw_qos, aw_region;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size, aw_prot;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last, w_user;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        r_valid, r_ready, r_last;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    axi4_burst_initiator dut (
        .clock(clock), .reset_n(reset_n),
        .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready), .io_cmd_bits_write(cmd_write),
        .io_cmd_bits_addr(cmd_addr), .io_cmd_bits_len(cmd_len), .io_cmd_bits_id(cmd_id),
        .io_wdata_valid(wdata_valid), .io_wdata_ready(wdata_ready),
        .io_wdata_bits_data(wdata_data), .io_wdata_bits_strb(wdata_strb),
        .io_rdata_valid(rdata_valid), .io_rdata_ready(rdata_ready),
        .io_rdata_bits_data(rdata_data), .io_rdata_bits_resp(rdata_resp),
        .io_rdata_bits_last(rdata_last),
        .io_wresp_valid(wresp_valid), .io_wresp_ready(wresp_ready),
        .io_wresp_bits_resp(wresp_resp), .io_busy(busy), .io_err_proto(err_proto),
        .io_mem_ar_valid(ar_valid), .io_mem_ar_ready(ar_ready), .io_mem_ar_bits_id(ar_id),
        .io_mem_ar_bits_addr(ar_addr), .io_mem_ar_bits_len(ar_len),
        .io_mem_ar_bits_size(ar_size), .io_mem_ar_bits_burst(ar_burst),
        .io_mem_ar_bits_lock(ar_lock), .io_mem_ar_bits_cache(ar_cache),
        .io_mem_ar_bits_prot(ar_prot), .io_mem_ar_bits_qos(ar_qos),
        .io_mem_ar_bits_region(ar_region), .io_mem_ar_bits_user(ar_user),
        .io_mem_aw_valid(aw_valid), .io_mem_aw_ready(aw_ready), .io_mem_aw_bits_id(aw_id),
        .io_mem_aw_bits_addr(aw_addr), .io_mem_aw_bits_len(aw_len),
        .io_mem_aw_bits_size(aw_size), .io_mem_aw_bits_burst(aw_burst),
        .io_mem_aw_bits_lock(aw_lock), .io_mem_aw_bits_cache(aw_cache),
        .io_mem_aw_bits_prot(aw_prot), .io_mem_aw_bits_qos(aw_qos),
        .io_mem_aw_bits_region(aw_region), .io_mem_aw_bits_user(aw_user),
        .io_mem_w_valid(w_valid), .io_mem_w_ready(w_ready), .io_mem_w_bits_data(w_data),
        .io_mem_w_bits_strb(w_strb), .io_mem_w_bits_last(w_last), .io_mem_w_bits_user(w_user),
        .io_mem_r_valid(r_valid), .io_mem_r_ready(r_ready), .io_mem_r_bits_id(r_id),
        .io_mem_r_bits_data(r_data), .io_mem_r_bits_resp(r_resp), .io_mem_r_bits_last(r_last),
        .io_mem_b_valid(b_valid), .io_mem_b_ready(b_ready), .io_mem_b_bits_id(b_id),
        .io_mem_b_bits_resp(b_resp)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        int          early;    // read beat index that carries a premature r_last, -1 none
        logic [1:0]  bresp;
        int          smax;     // max stall cycles on slave/consumer side
        logic        exp_err;  // io_err_proto expected after the command
    } vec_t;

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [127:0]  exp_q[$];
    vec_t          vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return {a, 16'hC0DE, kb, kb ^ 8'h5A};
    endfunction

    function automatic logic stall(input int smax);
        if (smax == 0) return 1'b1;
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l,
                             input logic [3:0] id);
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id; cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", 128'(cmd_ready), 128'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_read(input vec_t v);
        int wait_n, cyc, k, fires;
        logic fired, got_last;
        logic [127:0] e;
        issue_cmd(1'b0, v.addr, v.len, v.id);
        check("busy_after_cmd", 128'(busy), 128'd1);
        wait_n = $urandom_range(0, v.smax);
        cyc = 0;
        fired = 1'b0;
        while (!fired && cyc < 100) begin
            ar_ready = (wait_n == 0);
            #1;
            check("ar_payload", {ar_valid, ar_addr, ar_len, ar_id, ar_size, ar_burst,
                                 ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user},
                  {1'b1, v.addr, v.len, v.id, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
            fired = ar_valid && ar_ready;
            if (wait_n > 0) wait_n--;
            tick();
            cyc++;
        end
        if (!fired) check("ar_timeout", 128'd0, 128'd1);
        ar_ready = 1'b0;
        k = 0; fires = 0; cyc = 0; got_last = 1'b0; fired = 1'b0;
        wait_n = $urandom_range(0, v.smax);
        while (!got_last && cyc < 5000) begin
            if (fired) r_valid = 1'b0;
            fired = 1'b0;
            if (!r_valid) begin
                if (wait_n == 0) begin
                    r_valid = 1'b1; r_id = v.id; r_resp = 2'(k % 3); r_data = pat(v.addr, k);
                    r_last = (k == int'(v.len)) || (k == v.early);
                end else wait_n--;
            end
            rdata_ready = stall(v.smax);
            #1;
            if (r_valid && r_ready) begin
                exp_q.push_back({61'd0, r_data, r_last, r_resp});
                fires++;
                fired = 1'b1;
                got_last = r_last;
                k++;
                wait_n = $urandom_range(0, v.smax);
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_q.size() == 0) check("rdata_unexpected", 128'd1, 128'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rdata_beat", {61'd0, rdata_data, rdata_last, rdata_resp}, e);
                end
            end
            tick();
            cyc++;
        end
        r_valid = 1'b0; rdata_ready = 1'b0;
        #1;
        check("r_fire_count", 128'(fires), 128'((v.early >= 0) ? v.early + 1 : int'(v.len) + 1));
        check("r_queue_empty", 128'(exp_q.size()), 128'd0);
        check("rd_idle_after", {busy, cmd_ready}, 128'b01);
    endtask

    // abort_at >= 0 pulls reset_n low while that beat index is being offered.
    task automatic do_write(input vec_t v, input int abort_at);
        int wait_n, cyc, j;
        logic fired;
        logic [127:0] e;
        j = 0;
        wdata_valid = 1'b1; wdata_data = pat(v.addr, 0); wdata_strb = 8'hFF;
        exp_q.push_back({55'd0, wdata_data, wdata_strb, (v.len == 8'd0)});
        issue_cmd(1'b1, v.addr, v.len, v.id);
        wait_n = $urandom_range(0, v.smax);
        cyc = 0; fired = 1'b0;
        while (!fired && cyc < 100) begin
            aw_ready = (wait_n == 0);
            #1;
            check("aw_payload", {aw_valid, aw_addr, aw_len, aw_id, aw_size, aw_burst},
                  {1'b1, v.addr, v.len, v.id, 3'd3, 2'b01});
            check("w_before_aw", 128'(w_valid), 128'd0);
            fired = aw_valid && aw_ready;
            if (wait_n > 0) wait_n--;
            tick();
            cyc++;
        end
        if (!fired) check("aw_timeout", 128'd0, 128'd1);
        aw_ready = 1'b0;
        cyc = 0;
        while (j <= int'(v.len) && cyc < 5000) begin
            if (j == abort_at) begin
                w_ready = 1'b1;
                #1;
                reset_n = 1'b0;
                #1;
                check("reset_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready,
                                       rdata_valid, wresp_valid, wdata_ready, busy},
                      128'd0);
                check("reset_cmd_err", {cmd_ready, err_proto}, 128'b10);
                tick();
                reset_n = 1'b1;
                wdata_valid = 1'b0; w_ready = 1'b0;
                exp_q.delete();
                return;
            end
            w_ready = stall(v.smax);
            #1;
            check("w_valid_hold", {w_valid, w_data, w_strb},
                  {1'b1, pat(v.addr, j), 8'hFF});
            fired = w_valid && w_ready;
            if (fired) begin
                e = exp_q.pop_front();
                check("w_beat", {55'd0, w_data, w_strb, w_last}, e);
                j++;
            end
            tick();
            if (fired && j <= int'(v.len)) begin
                wdata_data = pat(v.addr, j);
                exp_q.push_back({55'd0, wdata_data, wdata_strb, (j == int'(v.len))});
            end
            cyc++;
        end
        wdata_valid = 1'b0; w_ready = 1'b0;
        wait_n = $urandom_range(0, v.smax);
        cyc = 0; fired = 1'b0;
        while (!fired && cyc < 100) begin
            b_valid = (wait_n == 0); b_id = v.id; b_resp = v.bresp;
            #1;
            check("b_ready", 128'(b_ready), 128'd1);
            fired = b_valid && b_ready;
            if (wait_n > 0) wait_n--;
            tick();
            cyc++;
        end
        if (!fired) check("b_timeout", 128'd0, 128'd1);
        b_valid = 1'b0;
        #1;
        check("wresp_hold", {wresp_valid, wresp_resp}, {1'b1, v.bresp});
        tick();
        wresp_ready = 1'b1;
        #1;
        check("wresp_out", {wresp_valid, wresp_resp, busy}, {1'b1, v.bresp, 1'b1});
        tick();
        wresp_ready = 1'b0;
        #1;
        check("wr_idle_after", {busy, cmd_ready}, 128'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t fresh;
        vecs[0] = '{1'b0, 32'h1000, 8'd3,   4'd2, -1, 2'b00, 0, 1'b0};
        vecs[1] = '{1'b1, 32'h2000, 8'd1,   4'd1, -1, 2'b00, 0, 1'b0};
        vecs[2] = '{1'b1, 32'h3000, 8'd3,   4'd5, -1, 2'b10, 2, 1'b0};
        vecs[3] = '{1'b0, 32'h4000, 8'd255, 4'd7, -1, 2'b00, 5, 1'b0};
        vecs[4] = '{1'b1, 32'h5000, 8'd7,   4'd3, -1, 2'b11, 5, 1'b0};
        vecs[5] = '{1'b0, 32'h6000, 8'd3,   4'd4,  1, 2'b00, 0, 1'b1};
        vecs[6] = '{1'b0, 32'h7000, 8'd2,   4'd9, -1, 2'b00, 3, 1'b1};
        vecs[7] = '{1'b1, 32'h8000, 8'd0,   4'd6, -1, 2'b01, 1, 1'b1};

        reset_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
        wdata_valid = 0; wdata_data = 0; wdata_strb = 0; rdata_ready = 0; wresp_ready = 0;
        ar_ready = 0; aw_ready = 0; w_ready = 0;
        r_valid = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0;
        b_valid = 0; b_id = 0; b_resp = 0;
        repeat (3) tick();
        #1;
        check("reset_state", {cmd_ready, busy, err_proto, ar_valid, aw_valid, w_valid,
                              rdata_valid, wresp_valid}, 128'b1000_0000);
        check("reset_ax_regs", {ar_addr, ar_len, ar_id, aw_addr, aw_len, aw_id}, 128'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) do_write(vecs[i], -1);
            else do_read(vecs[i]);
            check($sformatf("err_proto_v%0d", i), 128'(err_proto), 128'(vecs[i].exp_err));
        end

        // Reset during beat 2 of a len=7 write, then a clean write afterwards.
        fresh = '{1'b1, 32'h9000, 8'd7, 4'd8, -1, 2'b00, 0, 1'b0};
        do_write(fresh, 2);
        tick();
        #1;
        check("post_reset_idle", {busy, cmd_ready, err_proto}, 128'b010);
        fresh = '{1'b1, 32'hA000, 8'd2, 4'd1, -1, 2'b00, 2, 1'b0};
        do_write(fresh, -1);
        check("post_reset_err", 128'(err_proto), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axi4_burst_initiator.md
Name: axi4_burst_initiator

Overview:
- Synthesizable AXI4 master that issues one INCR burst (read or write) per command.
- Converts a simple command/stream interface into AR/AW/W channels and consumes R/B.
- Drives the io_mem_* ports of the DRAM simulation memory model or any AXI4 slave; used by memory test harnesses and DMA-style traffic generators.
- One transaction in flight at a time.

Parameters:
- ADDR_BITS, 32, AXI address width
- DATA_BITS, 64, AXI data width (power of two, >= 8)
- ID_BITS, 4, AXI ID width
- STRB_BITS, DATA_BITS/8, write strobe width

Ports:
- clock  in  1  single clock, all logic posedge
- reset_n  in  1  asynchronous active-low reset
- io_cmd_valid/io_cmd_ready  in/out  1/1  command handshake
- io_cmd_bits_write  in  1  1=write burst, 0=read burst
- io_cmd_bits_addr  in  ADDR_BITS  burst start address
- io_cmd_bits_len  in  8  beats minus one
- io_cmd_bits_id  in  ID_BITS  transaction ID
- io_wdata_valid/io_wdata_ready  in/out  1/1  write-beat stream
- io_wdata_bits_data/io_wdata_bits_strb  in  DATA_BITS/STRB_BITS  write beat payload
- io_rdata_valid/io_rdata_ready  out/in  1/1  read-beat stream
- io_rdata_bits_data/_resp/_last  out  DATA_BITS/2/1  read beat payload
- io_wresp_valid/io_wresp_ready  out/in  1/1  write completion
- io_wresp_bits_resp  out  2  BRESP of completed write
- io_busy  out  1  state != IDLE
- io_err_proto  out  1  sticky protocol-error flag
- io_mem_ar_*, io_mem_aw_*, io_mem_w_*, io_mem_r_*, io_mem_b_*  AXI4 master side: full field set of the memory model's io_mem bundle, directions mirrored

Behaviour:
- Reset (async assert, sync deassert by design; reset_n=0):
  - state=IDLE, beat counter=0, io_err_proto=0.
  - All valid and ready outputs low, except io_cmd_ready=1 after reset.
  - Registered AR/AW fields cleared to 0.
  - Reset mid-burst abandons the transaction immediately; no further beats are issued.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, WR_DONE.
- IDLE:
  - io_cmd_ready=1.
  - On cmd fire, latch addr/len/id into the AR or AW registers; go to RD_ADDR or WR_ADDR next cycle.
- Constant AR/AW fields:
  - burst=2'b01 (INCR), size=log2(STRB_BITS).
  - lock, cache, prot, qos, region, user all 0.
- RD_ADDR:
  - ar_valid=1 and held stable until ar_ready; fields must not change while valid.
  - On fire go to RD_DATA; counter=0.
- RD_DATA:
  - R passes combinationally to io_rdata: io_mem_r_ready=io_rdata_ready, io_rdata_valid=io_mem_r_valid.
  - Each fire increments the counter.
  - Beat with counter==len and r_last=1: return to IDLE.
  - Error cases set io_err_proto:
    - r_last=1 with counter!=len: also return to IDLE.
    - r_last=0 with counter==len: stay in RD_DATA and keep draining until r_last.
    - r_id != latched id: flag only.
- WR_ADDR: aw_valid held until aw_ready, then WR_DATA; counter=0. W is never issued before the AW handshake.
- WR_DATA:
  - io_mem_w_valid=io_wdata_valid; io_wdata_ready=io_mem_w_ready.
  - w_last=(counter==len); w_user=0.
  - On fire with counter==len go to WR_RESP.
- WR_RESP:
  - b_ready=1; on b fire latch bresp and go to WR_DONE.
  - b_id mismatch sets io_err_proto.
- WR_DONE: io_wresp_valid=1 until io_wresp_ready, then IDLE.
- Outside their owning state, all io_mem valid/ready outputs are 0.
- Counter is 8 bits; len=255 (256 beats) is legal with no wrap before the last beat.
- SLVERR/DECERR responses are forwarded unchanged and are not protocol errors.
- io_err_proto clears only on reset.
- Latency:
  - Command accept to ar/aw_valid: 1 cycle.
  - Last R or B fire to io_cmd_ready: 1 cycle (write path adds the WR_DONE handshake).

Test Plan:
- Read: cmd read addr=0x1000 len=3 id=2; slave returns 4 beats with ready always high -> ar_valid 1 cycle after cmd with addr=0x1000, len=3, size=3, burst=1; 4 rdata beats, last on beat 3; io_busy drops the cycle after.
- Write: cmd write addr=0x2000 len=1; two wdata beats strb=0xFF; bresp=0 -> no w_valid before aw fire; w_last only on the 2nd beat; io_wresp_valid with resp=0.
- Backpressure: random stall of ar_ready/w_ready/r_ready/io_rdata_ready 0-5 cycles -> AR/W payload stable while valid&&!ready; no beat lost or duplicated; 256-beat (len=255) read completes with exactly 256 fires.
- Protocol error: len=3 read, slave asserts r_last on beat 1 -> io_err_proto=1, back to IDLE, flag persists across the next good command.
- Slave error: write with bresp=2'b10 -> io_wresp_bits_resp=2, io_err_proto stays 0.
- Reset mid-op: reset_n low during beat 2 of a len=7 write -> all valids low in the same cycle, io_busy=0; a fresh command after release completes normally.
